program_loader: RTL



---
 rtl/program_loader.sv | 107 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: streams a {NI, ND, NI instruction words, ND data words} image into
// instruction and data memories, then enables the CPU until stopped.
module program_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_STEP  = 4,
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic [DATA_W-1:0] wdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error
);
    localparam int MAX_D = IMEM_DEPTH > DMEM_DEPTH ? IMEM_DEPTH : DMEM_DEPTH;
    localparam int CW    = $clog2(MAX_D + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR_I  = 3'd1;
    localparam logic [2:0] HDR_D  = 3'd2;
    localparam logic [2:0] LOAD_I = 3'd3;
    localparam logic [2:0] LOAD_D = 3'd4;
    localparam logic [2:0] RUN    = 3'd5;
    localparam logic [2:0] ERROR  = 3'd6;

    logic [2:0]        r_state, w_next;
    logic [DATA_W-1:0] r_ni, r_nd;
    logic [CW-1:0]     r_cnt;
    logic              r_wen_i, r_wen_d, r_cpu_en;
    logic [31:0]       r_addr_i, r_addr_d;
    logic [DATA_W-1:0] r_data_i, r_data_d;
    logic              w_beat, w_last, w_hdr_bad;

    assign in_ready  = r_state inside {HDR_I, HDR_D, LOAD_I, LOAD_D};
    assign busy      = in_ready;
    assign error     = r_state == ERROR;
    assign w_beat    = in_valid && in_ready;
    assign w_last    = DATA_W'(r_cnt) + DATA_W'(1) == (r_state == LOAD_I ? r_ni : r_nd);
    assign w_hdr_bad = r_ni > DATA_W'(IMEM_DEPTH) || in_data > DATA_W'(DMEM_DEPTH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, ERROR: w_next = start ? HDR_I : r_state;
            HDR_I:       w_next = w_beat ? HDR_D : HDR_I;
            HDR_D:       if (w_beat) w_next = w_hdr_bad ? ERROR : r_ni != '0 ? LOAD_I :
                                              in_data != '0 ? LOAD_D : RUN;
            LOAD_I:      if (w_beat && w_last) w_next = r_nd != '0 ? LOAD_D : RUN;
            LOAD_D:      if (w_beat && w_last) w_next = RUN;
            RUN:         w_next = stop ? IDLE : RUN;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= IDLE;
            r_ni     <= '0;
            r_nd     <= '0;
            r_cnt    <= '0;
            r_wen_i  <= 1'b0;
            r_wen_d  <= 1'b0;
            r_addr_i <= '0;
            r_addr_d <= '0;
            r_data_i <= '0;
            r_data_d <= '0;
            r_cpu_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_wen_i  <= w_beat && r_state == LOAD_I;
            r_wen_d  <= w_beat && r_state == LOAD_D;
            // registered from RUN so it rises on the edge the last write lands
            r_cpu_en <= r_state == RUN && !stop;
            if (w_beat && r_state == HDR_I) r_ni <= in_data;
            if (w_beat && r_state == HDR_D) r_nd <= in_data;
            if (w_beat && r_state == LOAD_I) begin
                r_addr_i <= 32'(r_cnt) * 32'(ADDR_STEP);
                r_data_i <= in_data;
            end
            if (w_beat && r_state == LOAD_D) begin
                r_addr_d <= 32'(r_cnt) * 32'(ADDR_STEP);
                r_data_d <= in_data;
            end
            if (w_next != r_state) r_cnt <= '0;
            else if (w_beat && (r_state == LOAD_I || r_state == LOAD_D)) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign addr_ext    = r_addr_i;
    assign wen_ext     = r_wen_i;
    assign wdata_ext   = r_data_i;
    assign addr_ext_2  = r_addr_d;
    assign wen_ext_2   = r_wen_d;
    assign wdata_ext_2 = r_data_d;
    assign cpu_enable  = r_cpu_en;
endmodule
